// File: rtl/display_mux_7seg_pkg.sv
// Shared constants for the 2-digit multiplexed 7-segment display driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}; anodes are active-low.
package display_mux_7seg_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;
  localparam logic [1:0] AN_OFF   = 2'b11;

  // Largest legal tens digit of a 60 s countdown.
  localparam logic [2:0] TENS_MAX = 3'd6;

  typedef enum logic {
    SEL_UNITS = 1'b0,
    SEL_TENS  = 1'b1
  } sel_e;

endpackage

// File: rtl/display_mux_7seg_bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern; values above 9
// decode to a dash so a corrupted digit is visibly wrong rather than blank.
module bcd_to_7seg
  import display_mux_7seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_DASH;
    case (digit)
      4'd0: pattern = SEG_0;
      4'd1: pattern = SEG_1;
      4'd2: pattern = SEG_2;
      4'd3: pattern = SEG_3;
      4'd4: pattern = SEG_4;
      4'd5: pattern = SEG_5;
      4'd6: pattern = SEG_6;
      4'd7: pattern = SEG_7;
      4'd8: pattern = SEG_8;
      4'd9: pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_mux_7seg.sv
// Time-multiplexed 2-digit common-anode display for the BCD countdown timer.
// Digits are latched once per scan frame; the display can blink while it reads 00.
module display_mux_7seg
  import display_mux_7seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 250,
  parameter int LZ_BLANK     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] q0,
  input  logic [2:0] q1,
  input  logic       blink_en,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       zero
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [RW-1:0] ref_cnt;
  sel_e          sel;
  logic [3:0]    shadow_u;
  logic [2:0]    shadow_t;
  logic [BW-1:0] blink_cnt;
  logic          phase;

  logic          tick;
  logic          frame;
  logic          lz_hide;
  logic [6:0]    u_pat;
  logic [6:0]    t_pat;
  logic [6:0]    t_seg;

  assign tick  = (ref_cnt == REF_LAST);
  assign frame = tick && (sel == SEL_TENS);

  bcd_to_7seg u_dec_units (
    .digit   (shadow_u),
    .pattern (u_pat)
  );

  bcd_to_7seg u_dec_tens (
    .digit   ({1'b0, shadow_t}),
    .pattern (t_pat)
  );

  assign t_seg   = (shadow_t > TENS_MAX) ? SEG_DASH : t_pat;
  // 00 must always show both digits, so only a non-zero units digit hides the tens.
  assign lz_hide = (LZ_BLANK != 0) && (shadow_t == 3'd0) && (shadow_u != 4'd0);

  // Scan timing and once-per-frame digit latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt  <= '0;
      sel      <= SEL_UNITS;
      shadow_u <= 4'd0;
      shadow_t <= 3'd0;
      zero     <= 1'b0;
    end else begin
      ref_cnt <= tick ? '0 : ref_cnt + RW'(1);
      if (tick) sel <= (sel == SEL_UNITS) ? SEL_TENS : SEL_UNITS;
      if (frame) begin
        shadow_u <= q0;
        shadow_t <= q1;
        zero     <= (q0 == 4'd0) && (q1 == 3'd0);
      end
    end
  end

  // Blink uses the already-latched zero, so a fresh 00 starts visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (!zero || !blink_en) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Registered output stage; lags sel by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else if (phase) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else if (sel == SEL_UNITS) begin
      an  <= AN_UNITS;
      seg <= u_pat;
    end else if (lz_hide) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an  <= AN_TENS;
      seg <= t_seg;
    end
  end

endmodule

// File: tb/tb_display_mux_7seg.sv
// Directed bench for display_mux_7seg with REFRESH_DIV=4, BLINK_FRAMES=2.
// With reset released on a negedge, frame boundaries fall on posedge 8, 16, 24, ...
module tb_display_mux_7seg;

  localparam logic [6:0] P0    = 7'b1000000;
  localparam logic [6:0] P1    = 7'b1111001;
  localparam logic [6:0] P2    = 7'b0100100;
  localparam logic [6:0] P3    = 7'b0110000;
  localparam logic [6:0] P5    = 7'b0010010;
  localparam logic [6:0] P7    = 7'b1111000;
  localparam logic [6:0] PDASH = 7'b0111111;
  localparam logic [6:0] POFF  = 7'b1111111;
  localparam logic [1:0] A_U   = 2'b10;
  localparam logic [1:0] A_T   = 2'b01;
  localparam logic [1:0] A_OFF = 2'b11;

  // Clock / reset / stimulus signals
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] q0 = 4'd0;
  logic [2:0] q1 = 3'd0;
  logic       blink_en = 1'b0;
  logic [6:0] seg, seg_lz;
  logic [1:0] an, an_lz;
  logic       zero, zero_lz;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  display_mux_7seg #(.REFRESH_DIV(4), .BLINK_FRAMES(2), .LZ_BLANK(0)) dut (
    .clk(clk), .reset(reset), .q0(q0), .q1(q1), .blink_en(blink_en),
    .seg(seg), .an(an), .zero(zero)
  );

  display_mux_7seg #(.REFRESH_DIV(4), .BLINK_FRAMES(2), .LZ_BLANK(1)) dut_lz (
    .clk(clk), .reset(reset), .q0(q0), .q1(q1), .blink_en(blink_en),
    .seg(seg_lz), .an(an_lz), .zero(zero_lz)
  );

  // Driver tasks: cyc = number of posedges since reset release; sampled on negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  // For k >= 9: output after posedge k belongs to the tens slot?
  function automatic bit tens_slot(input int k);
    return (((k - 9) / 4) % 2) == 1;
  endfunction

  task automatic test_reset();
    q0 = 4'd5; q1 = 3'd3; blink_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (seg !== POFF || an !== A_OFF || zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: got seg=%b an=%b zero=%b, want seg=%b an=%b zero=0",
               seg, an, zero, POFF, A_OFF);
    end
    reset = 1'b0;
    cyc = 0;
    run_to(1);
    checks++;
    if (seg !== P0 || an !== A_U || zero !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_units: got seg=%b an=%b zero=%b, want seg=%b an=%b zero=0",
               seg, an, zero, P0, A_U);
    end
    run_to(8);
    checks++;
    if (seg !== P0 || an !== A_T) begin
      failures++;
      $display("FAIL pre_boundary_tens: got seg=%b an=%b, want seg=%b an=%b", seg, an, P0, A_T);
    end
  endtask

  task automatic test_scan();
    logic [1:0] e_an;
    logic [6:0] e_seg;
    for (int k = 9; k <= 24; k++) begin
      run_to(k);
      e_an  = tens_slot(k) ? A_T : A_U;
      e_seg = tens_slot(k) ? P3 : P5;
      checks++;
      if (an !== e_an || seg !== e_seg) begin
        failures++;
        $display("FAIL scan_53 k=%0d: got seg=%b an=%b, want seg=%b an=%b", k, seg, an, e_seg, e_an);
      end
      checks++;
      if (an === 2'b00) begin
        failures++;
        $display("FAIL anodes_both_low k=%0d: got an=%b, want not 00", k, an);
      end
    end
    checks++;
    if (zero !== 1'b0) begin
      failures++;
      $display("FAIL scan_zero: got zero=%b, want 0", zero);
    end
  endtask

  task automatic test_midframe();
    logic [1:0] e_an;
    logic [6:0] e_seg;
    q0 = 4'd3; q1 = 3'd1; blink_en = 1'b0;
    apply_reset();
    run_to(10);
    q0 = 4'd2;
    for (int k = 11; k <= 20; k++) begin
      run_to(k);
      e_an  = tens_slot(k) ? A_T : A_U;
      e_seg = tens_slot(k) ? P1 : ((k <= 12) ? P3 : P2);
      checks++;
      if (an !== e_an || seg !== e_seg) begin
        failures++;
        $display("FAIL midframe k=%0d: got seg=%b an=%b, want seg=%b an=%b", k, seg, an, e_seg, e_an);
      end
    end
  endtask

  task automatic test_blink();
    logic [1:0] e_an;
    logic [6:0] e_seg;
    bit blank;
    q0 = 4'd0; q1 = 3'd0; blink_en = 1'b1;
    apply_reset();
    run_to(7);
    checks++;
    if (zero !== 1'b0) begin
      failures++;
      $display("FAIL zero_before_boundary: got zero=%b, want 0", zero);
    end
    run_to(8);
    checks++;
    if (zero !== 1'b1) begin
      failures++;
      $display("FAIL zero_after_boundary: got zero=%b, want 1", zero);
    end
    for (int k = 9; k <= 72; k++) begin
      run_to(k);
      if (k == 56) blink_en = 1'b0;
      blank = ((k >= 25) && (k <= 40)) || (k == 57);
      e_an  = blank ? A_OFF : (tens_slot(k) ? A_T : A_U);
      e_seg = blank ? POFF : P0;
      checks++;
      if (an !== e_an || seg !== e_seg) begin
        failures++;
        $display("FAIL blink k=%0d: got seg=%b an=%b, want seg=%b an=%b", k, seg, an, e_seg, e_an);
      end
    end
    checks++;
    if (zero !== 1'b1) begin
      failures++;
      $display("FAIL blink_zero_held: got zero=%b, want 1", zero);
    end
  endtask

  task automatic test_lz_blank();
    logic [1:0] e_an;
    logic [6:0] e_seg;
    q0 = 4'd7; q1 = 3'd0; blink_en = 1'b0;
    apply_reset();
    for (int k = 9; k <= 24; k++) begin
      run_to(k);
      e_an  = tens_slot(k) ? A_OFF : A_U;
      e_seg = tens_slot(k) ? POFF : P7;
      checks++;
      if (an_lz !== e_an || seg_lz !== e_seg) begin
        failures++;
        $display("FAIL lz_07 k=%0d: got seg=%b an=%b, want seg=%b an=%b", k, seg_lz, an_lz, e_seg, e_an);
      end
      e_an  = tens_slot(k) ? A_T : A_U;
      e_seg = tens_slot(k) ? P0 : P7;
      checks++;
      if (an !== e_an || seg !== e_seg) begin
        failures++;
        $display("FAIL no_lz_07 k=%0d: got seg=%b an=%b, want seg=%b an=%b", k, seg, an, e_seg, e_an);
      end
    end
    q0 = 4'd0;
    for (int k = 33; k <= 40; k++) begin
      run_to(k);
      e_an = tens_slot(k) ? A_T : A_U;
      checks++;
      if (an_lz !== e_an || seg_lz !== P0 || zero_lz !== 1'b1) begin
        failures++;
        $display("FAIL lz_00 k=%0d: got seg=%b an=%b zero=%b, want seg=%b an=%b zero=1",
                 k, seg_lz, an_lz, zero_lz, P0, e_an);
      end
    end
  endtask

  task automatic test_invalid();
    logic [1:0] e_an;
    q0 = 4'd12; q1 = 3'd7; blink_en = 1'b1;
    apply_reset();
    for (int k = 9; k <= 24; k++) begin
      run_to(k);
      e_an = tens_slot(k) ? A_T : A_U;
      checks++;
      if (an !== e_an || seg !== PDASH || zero !== 1'b0) begin
        failures++;
        $display("FAIL invalid k=%0d: got seg=%b an=%b zero=%b, want seg=%b an=%b zero=0",
                 k, seg, an, zero, PDASH, e_an);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] e_an;
    logic [6:0] e_seg;
    q0 = 4'd0; q1 = 3'd0; blink_en = 1'b1;
    apply_reset();
    run_to(44);
    checks++;
    if (an !== A_U || seg !== P0 || zero !== 1'b1) begin
      failures++;
      $display("FAIL pre_async_visible: got seg=%b an=%b zero=%b, want seg=%b an=%b zero=1",
               seg, an, zero, P0, A_U);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (seg !== POFF || an !== A_OFF || zero !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got seg=%b an=%b zero=%b, want seg=%b an=%b zero=0",
               seg, an, zero, POFF, A_OFF);
    end
    q0 = 4'd5; q1 = 3'd3;
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    for (int k = 9; k <= 16; k++) begin
      run_to(k);
      e_an  = tens_slot(k) ? A_T : A_U;
      e_seg = tens_slot(k) ? P3 : P5;
      checks++;
      if (an !== e_an || seg !== e_seg || zero !== 1'b0) begin
        failures++;
        $display("FAIL resume k=%0d: got seg=%b an=%b zero=%b, want seg=%b an=%b zero=0",
                 k, seg, an, zero, e_seg, e_an);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_midframe();
    test_blink();
    test_lz_blank();
    test_invalid();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
